// File: rtl/sys_pkg.sv
// Shared types and default sizing for the systolic array and its edge collectors.
package sys_pkg;

  localparam int SYS_COL_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int PSUM_WIDTH_DEF = 2 * DATA_WIDTH_DEF;

  typedef logic signed [PSUM_WIDTH_DEF-1:0] psum_t;

endpackage

// File: rtl/sys_row_fifo.sv
// Synchronous FIFO of multi-lane rows; the head row reads 0 whenever the FIFO is empty.
module sys_row_fifo
  import sys_pkg::*;
#(
  parameter int LANES = SYS_COL_DEF,
  parameter int WIDTH = PSUM_WIDTH_DEF,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_row [LANES],
  output logic [WIDTH-1:0] rd_row [LANES],
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH][LANES];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      for (int l = 0; l < LANES; l++) mem[wr_ptr[AW-1:0]][l] <= wr_row[l];
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      rd_row[l] = empty ? '0 : mem[rd_ptr[AW-1:0]][l];
    end
  end

endmodule

// File: rtl/sys_psum_deskew.sv
// Realigns column-skewed psums from sys_array into rows and buffers them in a FIFO.
// Optional feature: define SYS_DESKEW_RELU_EN to clamp negative lanes to 0 before buffering.
module sys_psum_deskew
  import sys_pkg::*;
#(
  parameter int SYS_COL    = SYS_COL_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PSUM_WIDTH = 2 * DATA_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [PSUM_WIDTH-1:0]   psum_in [0:SYS_COL-1],
  input  logic [SYS_COL-1:0]      en_in,
  output logic [PSUM_WIDTH-1:0]   out_row [0:SYS_COL-1],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    skew_err
);

  logic [PSUM_WIDTH-1:0] al_data [SYS_COL];
  logic [PSUM_WIDTH-1:0] wr_row  [SYS_COL];
  logic [SYS_COL-1:0]    al_en;
  logic                  row_ok;
  logic                  row_partial;
  logic                  pop;
  logic                  full;
  logic                  empty;

  // Column c waits SYS_COL-1-c cycles so every lane of a row lines up with the last column.
  for (genvar c = 0; c < SYS_COL; c++) begin : g_col
    localparam int D = SYS_COL - 1 - c;
    if (D == 0) begin : g_thru
      assign al_data[c] = psum_in[c];
      assign al_en[c]   = en_in[c];
    end else begin : g_dly
      logic [PSUM_WIDTH-1:0] d_q [D];
      logic                  e_q [D];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < D; i++) begin
            d_q[i] <= '0;
            e_q[i] <= 1'b0;
          end
        end else begin
          d_q[0] <= psum_in[c];
          e_q[0] <= en_in[c];
          for (int i = 1; i < D; i++) begin
            d_q[i] <= d_q[i-1];
            e_q[i] <= e_q[i-1];
          end
        end
      end
      assign al_data[c] = d_q[D-1];
      assign al_en[c]   = e_q[D-1];
    end
  end

  assign row_ok      = &al_en;
  assign row_partial = (|al_en) && !row_ok;

  always_comb begin
    for (int c = 0; c < SYS_COL; c++) begin
`ifdef SYS_DESKEW_RELU_EN
      wr_row[c] = al_data[c][PSUM_WIDTH-1] ? '0 : al_data[c];
`else
      wr_row[c] = al_data[c];
`endif
    end
  end

  // Downstream handshake: a row transfers on any edge where out_valid && out_ready;
  // out_valid and out_row depend only on registered FIFO state, never on out_ready.
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  sys_row_fifo #(
    .LANES (SYS_COL),
    .WIDTH (PSUM_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .push   (row_ok),
    .pop    (pop),
    .wr_row (wr_row),
    .rd_row (out_row),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else begin
      if (row_ok && full && !pop) overflow <= 1'b1;
      if (row_partial)            skew_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sys_psum_deskew.sv
// Randomized bench for sys_psum_deskew against a row-queue reference model.
module tb_sys_psum_deskew;

  localparam int SC    = 4;
  localparam int DW    = 16;
  localparam int PW    = 2 * DW;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int RW    = SC * PW;

  logic          clk = 1'b0;
  logic          rstn;
  logic [PW-1:0] psum_in [0:SC-1];
  logic [SC-1:0] en_in;
  logic [PW-1:0] out_row [0:SC-1];
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          overflow;
  logic          skew_err;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

  sys_psum_deskew #(.SYS_COL(SC), .DATA_WIDTH(DW), .PSUM_WIDTH(PW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .psum_in   (psum_in),
    .en_in     (en_in),
    .out_row   (out_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .skew_err  (skew_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Upstream schedule: slot[cycle % 16] holds the beats each lane carries that cycle.
  logic [SC-1:0] plan_en [16];
  logic [PW-1:0] plan_d  [16][SC];
  int            cyc = 0;

  // Reference model: last SC input cycles, queue of buffered rows, sticky flags.
  logic [SC-1:0] hist_en[$];
  logic [RW-1:0] hist_d[$];
  logic [RW-1:0] exp_q[$];
  logic          m_ovf;
  logic          m_skew;

  function automatic logic [RW-1:0] relu_row(input logic [RW-1:0] r);
    logic [RW-1:0] o;
    o = r;
`ifdef SYS_DESKEW_RELU_EN
    for (int c = 0; c < SC; c++) if (o[c*PW+PW-1]) o[c*PW +: PW] = '0;
`endif
    return o;
  endfunction

  function automatic logic [RW-1:0] dut_row();
    logic [RW-1:0] r;
    for (int c = 0; c < SC; c++) r[c*PW +: PW] = out_row[c];
    return r;
  endfunction

  function automatic logic [RW-1:0] make_row(input int base);
    logic [RW-1:0] r;
    for (int c = 0; c < SC; c++) r[c*PW +: PW] = PW'(base + c);
    return r;
  endfunction

  task automatic clear_plan();
    for (int s = 0; s < 16; s++) begin
      plan_en[s] = '0;
      for (int c = 0; c < SC; c++) plan_d[s][c] = '0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    hist_en.delete();
    hist_d.delete();
    m_ovf  = 1'b0;
    m_skew = 1'b0;
  endtask

  // Lane c of a row launched now appears on the wire c cycles later.
  task automatic launch_row(input logic [RW-1:0] row, input logic [SC-1:0] omit);
    for (int c = 0; c < SC; c++) begin
      plan_en[(cyc + c) % 16][c] = !omit[c];
      plan_d[(cyc + c) % 16][c]  = row[c*PW +: PW];
    end
  endtask

  // One clock edge of the reference: a row is complete once its last lane has arrived.
  task automatic model_edge();
    logic          do_pop;
    logic [SC-1:0] al_en;
    logic [RW-1:0] al_d;
    logic [RW-1:0] cur_d;
    int            n;
    int            idx;
    do_pop = (exp_q.size() > 0) && out_ready;
    for (int c = 0; c < SC; c++) cur_d[c*PW +: PW] = psum_in[c];
    hist_en.push_back(en_in);
    hist_d.push_back(cur_d);
    if (hist_en.size() > SC) begin
      void'(hist_en.pop_front());
      void'(hist_d.pop_front());
    end
    n     = hist_en.size();
    al_en = '0;
    al_d  = '0;
    for (int c = 0; c < SC; c++) begin
      idx = n - 1 - (SC - 1 - c);
      if (idx >= 0) begin
        al_en[c]          = hist_en[idx][c];
        al_d[c*PW +: PW]  = hist_d[idx][c*PW +: PW];
      end
    end
    if (do_pop) void'(exp_q.pop_front());
    if (&al_en) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(relu_row(al_d));
      else m_ovf = 1'b1;
    end else if (|al_en) begin
      m_skew = 1'b1;
    end
  endtask

  task automatic check_outputs();
    check("out_valid", RW'(out_valid), RW'(exp_q.size() > 0));
    check("count", RW'(count), RW'(exp_q.size()));
    check("overflow", RW'(overflow), RW'(m_ovf));
    check("skew_err", RW'(skew_err), RW'(m_skew));
    check("out_row", dut_row(), (exp_q.size() > 0) ? exp_q[0] : '0);
  endtask

  // driver: called at a negedge; drives one cycle, clocks, updates model, checks
  task automatic step();
    int s;
    s = cyc % 16;
    en_in = plan_en[s];
    for (int c = 0; c < SC; c++) begin
      psum_in[c] = plan_en[s][c] ? plan_d[s][c] : PW'($urandom);
      plan_d[s][c] = '0;
    end
    plan_en[s] = '0;
    @(posedge clk);
    if (rstn) model_edge();
    @(negedge clk);
    check_outputs();
    cyc++;
  endtask

  initial begin
    int            lat;
    logic [RW-1:0] r;
    rstn      = 1'b0;
    out_ready = 1'b0;
    en_in     = '0;
    for (int c = 0; c < SC; c++) psum_in[c] = '0;
    clear_plan();
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // single row 0x11,0x22,... : latency from column-0 beat to out_valid
    for (int c = 0; c < SC; c++) r[c*PW +: PW] = PW'(8'h11 * (c + 1));
    launch_row(r, '0);
    lat = 0;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      step();
      lat++;
    end
    check("latency", RW'(lat), RW'(SC));
    check("single_row", dut_row(), r);
    out_ready = 1'b1;
    step();
    check("single_pop_count", RW'(count), RW'(0));
    out_ready = 1'b0;

    // back-to-back rows, ready held high
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      launch_row(make_row(k * 16), '0);
      step();
    end
    repeat (SC + 2) step();

    // backpressure: 9 rows into an 8-deep FIFO, then push while full and popping
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      launch_row(make_row(256 + k * 16), '0);
      step();
    end
    repeat (SC) step();
    check("full_count", RW'(count), RW'(DEPTH));
    check("full_overflow", RW'(overflow), RW'(1));
    launch_row(make_row(1024), '0);
    repeat (SC - 1) step();
    out_ready = 1'b1;
    step();
    check("push_pop_full_count", RW'(count), RW'(DEPTH));
    repeat (DEPTH + 2) step();

    // broken skew: column 2 enable missing
    launch_row(make_row(2048), 4'b0100);
    repeat (SC) step();
    check("skew_flag", RW'(skew_err), RW'(1));
    launch_row(make_row(4096), '0);
    repeat (SC + 2) step();

    // reset with 3 rows buffered and one row part-way through the delay lines
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      launch_row(make_row(8192 + k * 16), '0);
      step();
    end
    repeat (3) step();
    launch_row(make_row(12288), '0);
    repeat (2) step();
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    clear_plan();
    check_outputs();
    @(negedge clk);
    repeat (2) step();
    rstn = 1'b1;
    out_ready = 1'b1;
    launch_row(make_row(16384), '0);
    repeat (SC + 2) step();

    // ReLU row {-5, 7, -1, 0}
    r[0*PW +: PW] = -PW'(5);
    r[1*PW +: PW] = PW'(7);
    r[2*PW +: PW] = -PW'(1);
    r[3*PW +: PW] = '0;
    out_ready = 1'b0;
    launch_row(r, '0);
    repeat (SC) step();
    check("relu_row", dut_row(), relu_row(r));
    out_ready = 1'b1;
    repeat (2) step();

    // randomized traffic with random backpressure and occasional broken rows
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        for (int c = 0; c < SC; c++) r[c*PW +: PW] = PW'($urandom);
        launch_row(r, ($urandom_range(0, 19) == 0) ? SC'($urandom_range(1, 14)) : '0);
      end
      step();
    end
    out_ready = 1'b1;
    repeat (SC + DEPTH + 2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sys_psum_deskew.md
# sys_psum_deskew

Output-side collector for `sys_array`. It takes the column-skewed partial sums (`psum_out`) and per-column enables (`en_out`) that leave the array's bottom edge one cycle apart per column. It realigns them into complete output rows, buffers those rows in a small FIFO, and hands them to downstream logic (accumulator or writeback) over a valid/ready handshake. It is the receiving counterpart of the skewed-data feeder that drives `sys_array` inputs.

## Interface
- `SYS_COL`, default 4: number of array columns, i.e. psum lanes.
- `DATA_WIDTH`, default 16: operand width; sets the psum width.
- `PSUM_WIDTH`, default `2*DATA_WIDTH`: width of each psum lane, two's complement.
- `DEPTH`, default 8: row-FIFO depth; must be a power of two, at least 2.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rstn`, input, 1: asynchronous, active-low reset.
- `psum_in[0:SYS_COL-1]`, input, `PSUM_WIDTH` each: connects to `sys_array.psum_out`.
- `en_in`, input, `SYS_COL`: per-column valid; connects to `sys_array.en_out`.
- `out_row[0:SYS_COL-1]`, output, `PSUM_WIDTH` each: aligned row at the FIFO head.
- `out_valid`, output, 1: FIFO is non-empty.
- `out_ready`, input, 1: downstream accepts `out_row` this cycle.
- `count`, output, `$clog2(DEPTH)+1`: rows currently held.
- `overflow`, output, 1: sticky; a row was dropped because the FIFO was full.
- `skew_err`, output, 1: sticky; the aligned enables were partially set.

## Operation
- **Deskew.** Column c passes through `SYS_COL-1-c` register stages, carrying both data and enable.
  - Column `SYS_COL-1` is not delayed.
  - A row whose column 0 arrives at cycle t therefore presents all lanes aligned at cycle `t+SYS_COL-1`.
- **Row write.** When all aligned enables are 1, the aligned row is pushed into the FIFO on that clock edge.
- **Partial enables.** If some but not all aligned enables are 1:
  - `skew_err` is set.
  - Nothing is written.
  - The remaining beats are discarded.
- **Full FIFO.**
  - A push while full with no pop in the same cycle is dropped and sets `overflow`.
  - A push while full with a simultaneous pop (`out_valid && out_ready`) succeeds; `count` is unchanged.
- **Pop.** Occurs when `out_valid && out_ready`. Pushes and pops in the same cycle are independent.
- **No bypass.** When the FIFO is empty, a row pushed at edge e gives `out_valid` after edge e.
- **Clearing errors.** `overflow` and `skew_err` clear only on reset.
- **Reset values.** All delay stages, FIFO pointers, `count`, `out_valid`, `overflow` and `skew_err` are 0. `out_row` reads 0.
- **Reset mid-row.** Partially deskewed beats are lost, and no row is written for them.
- **Arithmetic.** None is performed on the data path apart from the optional ReLU (see Configuration).

## Timing
- **Latency.** Column `SYS_COL-1` beat in cycle t → `out_valid` = 1 in cycle t+1 (FIFO empty case). Column 0 beat in cycle t → `out_valid` in cycle `t+SYS_COL`.
- **Throughput.** One row per cycle, sustained, while `out_ready` = 1.
- **`out_row` stability.** `out_row` and `out_valid` are stable while `out_valid && !out_ready`.
- **`out_ready` path.** `out_ready` has no combinational path to `out_valid` or `out_row`.
- **`count` timing.** `count` updates on the edge of the push or pop.

## Configuration
- **`SYS_DESKEW_RELU_EN` defined.** Each lane is clamped to 0 if negative (MSB = 1) before the FIFO write. This adds no latency.
- **`SYS_DESKEW_RELU_EN` undefined.** Lanes pass through unchanged.

## Structure
- **Shared package `sys_pkg`.**
  - `psum_t`, a typedef of `logic signed [PSUM_WIDTH-1:0]`, shared with `sys_array`.
  - Default constants `SYS_COL_DEF` and `DATA_WIDTH_DEF`.
- **Sub-module `sys_row_fifo`.** A synchronous FIFO of `SYS_COL`-lane rows exposing `push`, `pop`, `full`, `empty` and `count`. The deskew delay lines stay in the top module as a generate loop.

## Test plan
- **Single row.** `en_in[c]` = 1 in cycle c, with `psum_in[c]` = `0x11*(c+1)` (so 0x11, 0x22, 0x33, 0x44 for `SYS_COL`=4) → `out_valid` rises in cycle 4 with `out_row` = {0x11,0x22,0x33,0x44}. `count` = 1; it returns to 0 after a pop with `out_ready`=1.
- **Back-to-back rows.** 4 skewed rows with values r·16+c, `out_ready` held 1 → 4 consecutive valid cycles, in order, each row correct, with no gaps.
- **Backpressure and overflow.** `out_ready`=0 while 9 rows are pushed (`DEPTH`=8) → `count` saturates at 8, `overflow`=1, and the FIFO holds rows 0–7. Then raise `out_ready`, push a row while full and popping → no further drop, `count` stays 8.
- **Broken skew.** Column 2's enable omitted for one row → `skew_err`=1, no row written, and the next well-formed row is delivered correctly.
- **Reset mid-operation.** Assert `rstn`=0 asynchronously with 3 rows buffered and one partially deskewed → all outputs 0 immediately. After release, a new row is delivered and no stale data appears.
- **ReLU.** With `SYS_DESKEW_RELU_EN` defined, a row {-5, 7, -1, 0} → `out_row` = {0, 7, 0, 0}. Without the macro, the row is delivered unchanged.
